// File: rtl/reg_file_pkg.sv
// Shared definitions for the register-file access controller:
// default widths, FSM state encoding and the hard-wired zero register.
package reg_file_pkg;

  localparam int RF_AW    = 5;
  localparam int RF_DW    = 32;
  localparam int REG_ZERO = 0;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_RUN  = 2'd1,
    ST_DBG  = 2'd2
  } rf_state_e;

endpackage

// File: rtl/reg_file_starve_cnt.sv
// Request-age counter for shared-resource arbiters. It counts consecutive
// cycles a request has been pending and raises hit_o on the cycle the request
// must be forced through. The counter saturates at LIM-1 and clears whenever
// the request is not counting or the forced grant fires.
module reg_file_starve_cnt #(
  parameter int LIM = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc_i,
  input  logic clr_i,
  output logic hit_o
);

  localparam int W = (LIM > 2) ? $clog2(LIM) : 1;

  logic [W-1:0] cnt_q, cnt_d;

  // The grant fires once the incremented age would reach LIM-1, so the
  // forced access lands on the LIM-th pending cycle.
  always_comb begin
    hit_o = inc_i && ((int'(cnt_q) + 2) >= LIM);
    cnt_d = cnt_q;
    if (clr_i || !inc_i || hit_o)
      cnt_d = '0;
    else if (cnt_q != W'(LIM - 1))
      cnt_d = cnt_q + W'(1);
  end

  // Age register with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/reg_file_ctrl.sv
// Access controller for the pipeline register file (2R/1W, combinational
// read). After reset it clears every register, then shares the RF ports
// between the pipeline and a debug requester, suppressing writes to r0 and
// registering all read data.
// Optional build macro: RF_BYPASS_EN -- forward same-cycle pipeline write
// data into the captured pipeline read data.
module reg_file_ctrl
  import reg_file_pkg::*;
#(
  parameter int AW         = RF_AW,
  parameter int DW         = RF_DW,
  parameter int STARVE_LIM = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          p_rw,
  input  logic [AW-1:0] p_rn1,
  input  logic [AW-1:0] p_rn2,
  input  logic [AW-1:0] p_wn,
  input  logic [DW-1:0] p_wd,
  output logic [DW-1:0] p_rd1,
  output logic [DW-1:0] p_rd2,
  output logic          p_stall,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wd,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic          init_done,
  output logic          rf_regwrite,
  output logic [AW-1:0] rf_rn1,
  output logic [AW-1:0] rf_rn2,
  output logic [AW-1:0] rf_wn,
  output logic [DW-1:0] rf_wd,
  input  logic [DW-1:0] rf_rd1,
  input  logic [DW-1:0] rf_rd2
);

  rf_state_e     state_q, state_d;
  logic [AW-1:0] clr_cnt_q, clr_cnt_d;
  logic          init_done_q, init_done_d;
  logic          d_ack_q, d_ack_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;
  logic [DW-1:0] p_rd1_q, p_rd1_d;
  logic [DW-1:0] p_rd2_q, p_rd2_d;
  logic          clr_last;
  logic          dbg_hit;
  logic          byp1, byp2;

  assign clr_last = (clr_cnt_q == '1);

  reg_file_starve_cnt #(.LIM(STARVE_LIM)) u_starve (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (state_q == ST_RUN && d_req),
    .clr_i (state_q != ST_RUN),
    .hit_o (dbg_hit)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_INIT;
    else        state_q <= state_d;
  end

  // Next state: clear sweep, then pipeline ownership with forced debug slots.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_INIT: if (clr_last) state_d = ST_RUN;
      ST_RUN:  if (dbg_hit)  state_d = ST_DBG;
      ST_DBG:  state_d = ST_RUN;
      default: state_d = ST_INIT;
    endcase
  end

  // RF port steering and stall; writes to r0 are filtered outside the sweep.
  always_comb begin
    rf_regwrite = 1'b0;
    rf_rn1      = p_rn1;
    rf_rn2      = p_rn2;
    rf_wn       = p_wn;
    rf_wd       = p_wd;
    p_stall     = 1'b0;
    unique case (state_q)
      ST_INIT: begin
        rf_regwrite = 1'b1;
        rf_wn       = clr_cnt_q;
        rf_wd       = '0;
        p_stall     = 1'b1;
      end
      ST_RUN: rf_regwrite = p_rw && (p_wn != AW'(REG_ZERO));
      ST_DBG: begin
        rf_rn1      = d_addr;
        rf_rn2      = d_addr;
        rf_regwrite = d_we && (d_addr != AW'(REG_ZERO));
        rf_wn       = d_addr;
        rf_wd       = d_wd;
        p_stall     = 1'b1;
      end
      default: p_stall = 1'b1;
    endcase
  end

`ifdef RF_BYPASS_EN
  // Pipeline write data wins over the stale RF value for a same-cycle read.
  assign byp1 = (state_q == ST_RUN) && rf_regwrite && (p_rn1 == p_wn);
  assign byp2 = (state_q == ST_RUN) && rf_regwrite && (p_rn2 == p_wn);
`else
  assign byp1 = 1'b0;
  assign byp2 = 1'b0;
`endif

  // Datapath next-state: sweep counter, read capture, debug completion.
  always_comb begin
    clr_cnt_d   = '0;
    init_done_d = init_done_q;
    d_ack_d     = 1'b0;
    d_rdata_d   = d_rdata_q;
    p_rd1_d     = p_rd1_q;
    p_rd2_d     = p_rd2_q;
    unique case (state_q)
      ST_INIT: begin
        clr_cnt_d = clr_cnt_q + AW'(1);
        if (clr_last) init_done_d = 1'b1;
      end
      ST_RUN: begin
        p_rd1_d = byp1 ? p_wd : rf_rd1;
        p_rd2_d = byp2 ? p_wd : rf_rd2;
      end
      ST_DBG: begin
        d_ack_d   = 1'b1;
        d_rdata_d = rf_rd1;
      end
      default: ;
    endcase
  end

  // Datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clr_cnt_q   <= '0;
      init_done_q <= 1'b0;
      d_ack_q     <= 1'b0;
      d_rdata_q   <= '0;
      p_rd1_q     <= '0;
      p_rd2_q     <= '0;
    end else begin
      clr_cnt_q   <= clr_cnt_d;
      init_done_q <= init_done_d;
      d_ack_q     <= d_ack_d;
      d_rdata_q   <= d_rdata_d;
      p_rd1_q     <= p_rd1_d;
      p_rd2_q     <= p_rd2_d;
    end
  end

  assign p_rd1     = p_rd1_q;
  assign p_rd2     = p_rd2_q;
  assign d_ack     = d_ack_q;
  assign d_rdata   = d_rdata_q;
  assign init_done = init_done_q;

endmodule

// File: tb/tb_reg_file_ctrl.sv
// Directed bench for reg_file_ctrl with a behavioural 32x32 register file
// attached and a shadow model plus expected-value queue for the read paths.
module tb_reg_file_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        p_rw;
  logic [4:0]  p_rn1, p_rn2, p_wn;
  logic [31:0] p_wd;
  logic [31:0] p_rd1, p_rd2;
  logic        p_stall;
  logic        d_req, d_we;
  logic [4:0]  d_addr;
  logic [31:0] d_wd;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        init_done;
  logic        rf_regwrite;
  logic [4:0]  rf_rn1, rf_rn2, rf_wn;
  logic [31:0] rf_wd;
  logic [31:0] rf_rd1, rf_rd2;

  logic [31:0] rf_mem [32];
  logic [31:0] shadow [32];
  logic [31:0] exp_q [$];
  int          total = 0;
  int          passed = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  reg_file_ctrl #(.AW(5), .DW(32), .STARVE_LIM(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .p_rw(p_rw), .p_rn1(p_rn1), .p_rn2(p_rn2), .p_wn(p_wn), .p_wd(p_wd),
    .p_rd1(p_rd1), .p_rd2(p_rd2), .p_stall(p_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wd(d_wd),
    .d_ack(d_ack), .d_rdata(d_rdata), .init_done(init_done),
    .rf_regwrite(rf_regwrite), .rf_rn1(rf_rn1), .rf_rn2(rf_rn2),
    .rf_wn(rf_wn), .rf_wd(rf_wd), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2)
  );

  // Register file: combinational read, write on posedge.
  assign rf_rd1 = rf_mem[rf_rn1];
  assign rf_rd2 = rf_mem[rf_rn2];
  always @(posedge clk) if (rf_regwrite) rf_mem[rf_wn] <= rf_wd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Expect a full 32-cycle clear sweep starting now, then init_done.
  task automatic sweep(input string tag);
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      chk({tag, ".wn"}, 32'(rf_wn), i);
      chk({tag, ".we"}, 32'(rf_regwrite), 1);
      chk({tag, ".wd"}, rf_wd, 0);
      chk({tag, ".stall"}, 32'(p_stall), 1);
      chk({tag, ".done0"}, 32'(init_done), 0);
      tick();
    end
    chk({tag, ".done1"}, 32'(init_done), 1);
    chk({tag, ".run_stall"}, 32'(p_stall), 0);
    for (int i = 0; i < 32; i++) shadow[i] = '0;
  endtask

  // One pipeline cycle: expected read data queued at drive time.
  task automatic pipe(input logic rw, input logic [4:0] wn, input logic [31:0] wd,
                      input logic [4:0] r1, input logic [4:0] r2, input string tag);
    logic [31:0] e1, e2;
    p_rw = rw; p_wn = wn; p_wd = wd; p_rn1 = r1; p_rn2 = r2;
    e1 = shadow[r1];
    e2 = shadow[r2];
`ifdef RF_BYPASS_EN
    if (rw && wn != 0 && r1 == wn) e1 = wd;
    if (rw && wn != 0 && r2 == wn) e2 = wd;
`endif
    exp_q.push_back(e1);
    exp_q.push_back(e2);
    @(negedge clk);
    chk({tag, ".we"}, 32'(rf_regwrite), 32'(rw && wn != 0));
    tick();
    if (rw && wn != 0) shadow[wn] = wd;
    chk({tag, ".rd1"}, p_rd1, exp_q.pop_front());
    chk({tag, ".rd2"}, p_rd2, exp_q.pop_front());
    p_rw = 1'b0;
  endtask

  // Debug access; pipeline reads r0 meanwhile so a non-holding p_rd1 shows up.
  task automatic dbg(input logic we, input logic [4:0] a, input logic [31:0] wd, input string tag);
    int stall_cyc = 0;
    bit got = 0;
    p_rn1 = 5'd0; p_rn2 = 5'd0; p_rw = 1'b0;
    d_req = 1'b1; d_we = we; d_addr = a; d_wd = wd;
    exp_q.push_back(shadow[a]);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (p_stall && stall_cyc == 0) begin
        stall_cyc = c;
        chk({tag, ".we"}, 32'(rf_regwrite), 32'(we && a != 0));
      end
      if (d_ack && !got) begin
        got = 1;
        chk({tag, ".rdata"}, d_rdata, exp_q.pop_front());
        chk({tag, ".hold"}, p_rd1, 0);
        chk({tag, ".ackstall"}, 32'(p_stall), 0);
      end
      tick();
      if (got) break;
    end
    chk({tag, ".got_ack"}, 32'(got), 1);
    if (!got) void'(exp_q.pop_front());
    chk({tag, ".stall_cyc"}, stall_cyc, 4);
    d_req = 1'b0;
    chk({tag, ".pulse"}, 32'(d_ack), 0);
    tick();
    if (we && a != 0) shadow[a] = wd;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf_mem[i] = 32'hBAD0_0000 | 32'(i);
    rst_n = 1'b0; p_rw = 0; p_rn1 = 0; p_rn2 = 0; p_wn = 0; p_wd = 0;
    d_req = 0; d_we = 0; d_addr = 0; d_wd = 0;
    tick(); tick();
    chk("rst.rd1", p_rd1, 0);
    chk("rst.rd2", p_rd2, 0);
    chk("rst.rdata", d_rdata, 0);
    chk("rst.ack", 32'(d_ack), 0);
    chk("rst.done", 32'(init_done), 0);
    chk("rst.stall", 32'(p_stall), 1);

    // Interrupt the clear at count 10, then expect a full restart.
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    @(negedge clk);
    chk("mid.wn10", 32'(rf_wn), 10);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    sweep("init");

    for (int i = 0; i < 16; i++) pipe(1'b0, 5'd0, 0, 5'(2 * i), 5'(2 * i + 1), "clr");

    pipe(1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd1, "w5");
    pipe(1'b0, 5'd0, 0, 5'd5, 5'd0, "r5");
    pipe(1'b1, 5'd0, 32'h1234, 5'd0, 5'd5, "w0");
    pipe(1'b0, 5'd0, 0, 5'd1, 5'd0, "r0");
    pipe(1'b1, 5'd3, 32'h0F0F_0F0F, 5'd5, 5'd3, "w3");
    pipe(1'b0, 5'd0, 0, 5'd3, 5'd5, "r3");

    dbg(1'b0, 5'd5, 0, "dread");
    dbg(1'b1, 5'd7, 32'hA5A5A5A5, "dwr7");
    pipe(1'b0, 5'd0, 0, 5'd7, 5'd3, "r7");
    dbg(1'b1, 5'd0, 32'hFFFF_FFFF, "dwr0");
    pipe(1'b0, 5'd0, 0, 5'd0, 5'd7, "r0b");

    // Reset during the debug slot: no ack, clear restarts.
    d_req = 1'b1; d_we = 1'b0; d_addr = 5'd5; p_rn1 = 0; p_rn2 = 0;
    begin
      bit seen = 0;
      for (int c = 0; c < 12 && !seen; c++) begin
        @(negedge clk);
        if (p_stall) seen = 1;
        else tick();
      end
      chk("rdbg.reached", 32'(seen), 1);
    end
    rst_n = 1'b0;
    tick();
    d_req = 1'b0;
    chk("rdbg.ack", 32'(d_ack), 0);
    chk("rdbg.done", 32'(init_done), 0);
    chk("rdbg.stall", 32'(p_stall), 1);
    rst_n = 1'b1;
    sweep("reinit");
    pipe(1'b0, 5'd0, 0, 5'd5, 5'd7, "post");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/reg_file_ctrl.md
Name: reg_file_ctrl

Overview:
Access controller for the 32x32 pipeline register file (2 read ports, 1 write port, combinational read, write on posedge).
- After reset, sequences a clear of every register to zero.
- Afterwards shares the RF ports between the pipeline (decode read / writeback write) and a debug requester.
- Suppresses writes to register 0 and registers all read data toward requesters.

Parameters:
AW, 5, register address width (NREG = 2**AW)
DW, 32, data width
STARVE_LIM, 4, consecutive cycles a pending debug request may be blocked before it is forced through (min 1)

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous active-low
p_rw  in  1  pipeline write enable
p_rn1  in  AW  pipeline read address 1
p_rn2  in  AW  pipeline read address 2
p_wn  in  AW  pipeline write address
p_wd  in  DW  pipeline write data
p_rd1  out  DW  registered read data 1
p_rd2  out  DW  registered read data 2
p_stall  out  1  pipeline must hold its request this cycle
d_req  in  1  debug request (level, held until d_ack)
d_we  in  1  debug write (1) / read (0)
d_addr  in  AW  debug register address
d_wd  in  DW  debug write data
d_ack  out  1  one-cycle completion pulse
d_rdata  out  DW  debug read data, valid with d_ack
init_done  out  1  high once clear sequence finished
rf_regwrite  out  1  to RF RegWrite
rf_rn1  out  AW  to RF RN1
rf_rn2  out  AW  to RF RN2
rf_wn  out  AW  to RF WN
rf_wd  out  DW  to RF WD
rf_rd1  in  DW  from RF RD1
rf_rd2  in  DW  from RF RD2

Behaviour:
- Clock `clk` and reset `rst_n`: one clock; reset is synchronous and active-low. All state updates on posedge clk only.
- Reset values: p_rd1 = p_rd2 = 0, d_rdata = 0, d_ack = 0, init_done = 0, state = INIT, clear counter = 0, starve counter = 0.
- p_stall is combinational from the state: 1 in INIT and DBG, else 0.
- FSM states: INIT, RUN, DBG.
- INIT:
  - rf_regwrite = 1, rf_wn = counter, rf_wd = 0; counter increments each cycle.
  - After the write of address NREG-1 (NREG cycles total): go to RUN and set init_done = 1.
  - d_req is ignored (waits) and pipeline inputs are ignored.
- RUN, pipeline owns the ports:
  - rf_rn1/rf_rn2 = p_rn1/p_rn2; rf_wn = p_wn; rf_wd = p_wd.
  - rf_regwrite = p_rw AND (p_wn != 0).
  - Next cycle: p_rd1/p_rd2 <= rf_rd1/rf_rd2 (1-cycle latency).
- Starvation counter:
  - In RUN, while d_req = 1 the starve counter increments each cycle; while d_req = 0 it clears.
  - When d_req = 1 and the counter reaches STARVE_LIM-1, next state is DBG and the counter clears.
  - Debug never preempts INIT.
- DBG (exactly one cycle):
  - rf_rn1 = d_addr; rf_regwrite = d_we AND (d_addr != 0); rf_wn = d_addr; rf_wd = d_wd.
  - Pipeline request is dropped; the pipeline sees p_stall and must re-present it.
  - Next cycle: d_ack = 1 and d_rdata <= rf_rd1 (read data, or pre-write value on a write), p_rd1/p_rd2 hold their values, return to RUN.
- Address 0: reads pass through (RF returns 0 after INIT); writes are never issued outside INIT.
- Reset asserted in any state, including mid-INIT or in DBG: return to reset values next edge and restart the clear at address 0; no d_ack is produced for an interrupted request.

Optional Feature:
RF_BYPASS_EN:
- Defined: in RUN, if rf_regwrite = 1 and p_rn1 == p_wn, the value captured into p_rd1 is p_wd instead of rf_rd1; same for p_rd2/p_rn2. Write-before-read in the same cycle.
- Undefined: p_rd* always capture rf_rd*, i.e. pre-write values.
- DBG reads are never bypassed.

Decomposition:
- Shared package reg_file_pkg: AW/DW defaults, state encoding (INIT=2'd0, RUN=2'd1, DBG=2'd2), REG_ZERO constant.
- Natural sub-module: reg_file_starve_cnt (saturating request-age counter with clear), reused by other shared-resource arbiters.

Test Plan:
- Reset release: init_done = 0 and p_stall = 1 for exactly 32 cycles, rf_wn sweeps 0..31 with rf_wd = 0; then init_done = 1; reading all regs gives 0.
- Pipeline p_rw = 1, p_wn = 5, p_wd = 32'hDEADBEEF; next cycle p_rn1 = 5 -> p_rd1 = 32'hDEADBEEF one cycle later. Same-cycle read of 5: old value without the macro, DEADBEEF with RF_BYPASS_EN.
- p_rw = 1, p_wn = 0, p_wd = 32'h1234 -> rf_regwrite = 0; subsequent read of reg 0 returns 0.
- d_req = 1 read of addr 5 with STARVE_LIM = 4 -> p_stall high on the 4th cycle, d_ack pulse next cycle with d_rdata = 32'hDEADBEEF, back to RUN.
- Debug write d_addr = 7, d_wd = 32'hA5A5A5A5 -> after d_ack, pipeline read of reg 7 returns A5A5A5A5.
- rst_n low for one cycle at INIT count 10 -> clear restarts at address 0, full 32 cycles before init_done = 1; rst_n during DBG -> no d_ack.
